// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue between fetch and decode.
package fetch_queue_pkg;

  localparam int FQ_XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] inst;
    logic               misaligned;
  } fq_entry_t;

endpackage

// File: rtl/fq_pc_inc.sv
// Compressed-instruction detect and next-sequential-PC for the queue head.
module fq_pc_inc
  import fetch_queue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [1:0]      inst_lsb_i,
  output logic            compr_o,
  output logic [XLEN-1:0] pc_plus_o
);

  assign compr_o   = (inst_lsb_i != 2'b11);
  assign pc_plus_o = pc_i + (compr_o ? XLEN'(2) : XLEN'(4));

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode with flush support.
// Define FETCH_QUEUE_STATS_EN to add stall_cycles / flush_events counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = FQ_XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_inst,
  input  logic                     in_misaligned,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_inst,
  output logic [XLEN-1:0]          out_pc_plus,
  output logic                     out_compr,
  output logic                     out_misaligned,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              flush_events
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t     mem_q [DEPTH];
  fq_entry_t     wr_entry;
  fq_entry_t     head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, empty;

  // in_ready comes from registered count only, so a full queue refuses a push even while popping
  assign in_ready  = (count_q < CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign out_valid = !empty && !flush;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  assign wr_entry = '{pc: FQ_XLEN'(in_pc), inst: FQ_XLEN'(in_inst), misaligned: in_misaligned};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; every output below is masked while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head           = mem_q[rd_ptr_q];
  assign out_pc         = empty ? '0 : head.pc[XLEN-1:0];
  assign out_inst       = empty ? XLEN'(NOP_INST) : head.inst[XLEN-1:0];
  assign out_misaligned = empty ? 1'b0 : head.misaligned;

  fq_pc_inc #(.XLEN(XLEN)) u_pc_inc (
    .pc_i       (out_pc),
    .inst_lsb_i (out_inst[1:0]),
    .compr_o    (out_compr),
    .pc_plus_o  (out_pc_plus)
  );

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (in_valid && !in_ready && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush && flush_events_q != '1) flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_inst;
  logic            in_misaligned;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc_plus;
  logic            out_compr;
  logic            out_misaligned;
  logic [CW-1:0]   count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0]     stall_cycles;
  logic [31:0]     flush_events;
  bit   [31:0]     mdlStall;
  bit   [31:0]     mdlFlushEv;
`endif

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_inst        (in_inst),
    .in_misaligned  (in_misaligned),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_pc_plus    (out_pc_plus),
    .out_compr      (out_compr),
    .out_misaligned (out_misaligned),
    .count          (count)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] pc;
    bit [31:0] inst;
    bit        mis;
  } entry_t;

  typedef struct {
    bit        rst;
    bit        iv;
    bit [31:0] pc;
    bit [31:0] inst;
    bit        mis;
    bit        fl;
    bit        ordy;
    bit        expValid;
    bit [31:0] expPc;
    bit [31:0] expInst;
    bit [31:0] expPlus;
    bit        expCompr;
    bit        expMis;
    bit [31:0] expCount;
    bit        expReady;
  } vec_t;

  entry_t mq[$];
  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic driveInputs(input bit r, input bit iv, input bit [31:0] pc, input bit [31:0] inst,
                             input bit mis, input bit fl, input bit ordy);
    rst = r; in_valid = iv; in_pc = pc; in_inst = inst;
    in_misaligned = mis; flush = fl; out_ready = ordy;
  endtask

  // Reference model: a plain FIFO of entries, updated from the inputs seen at each edge
  function automatic void modelEdge();
    bit canPush;
    bit canPop;
    canPush = in_valid && (mq.size() < DEPTH);
    canPop  = (mq.size() != 0) && out_ready;
`ifdef FETCH_QUEUE_STATS_EN
    if (rst) begin
      mdlStall = 0;
      mdlFlushEv = 0;
    end else begin
      if (in_valid && mq.size() >= DEPTH && mdlStall != 32'hFFFFFFFF) mdlStall++;
      if (flush && mdlFlushEv != 32'hFFFFFFFF) mdlFlushEv++;
    end
`endif
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (canPop) void'(mq.pop_front());
      if (canPush) mq.push_back('{pc: in_pc, inst: in_inst, mis: in_misaligned});
    end
  endfunction

  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkOutput();
    bit [31:0] ePc;
    bit [31:0] eInst;
    bit        eMis;
    bit        eCompr;
    if (mq.size() == 0) begin
      ePc = 0; eInst = 32'h00000013; eMis = 0;
    end else begin
      ePc = mq[0].pc; eInst = mq[0].inst; eMis = mq[0].mis;
    end
    eCompr = (eInst % 4) != 3;
    checkVal("out_valid", out_valid, (mq.size() != 0) && !flush);
    checkVal("in_ready", in_ready, mq.size() < DEPTH);
    checkVal("count", count, mq.size());
    checkVal("out_pc", out_pc, ePc);
    checkVal("out_inst", out_inst, eInst);
    checkVal("out_misaligned", out_misaligned, eMis);
    checkVal("out_compr", out_compr, eCompr);
    checkVal("out_pc_plus", out_pc_plus, ePc + (eCompr ? 32'd2 : 32'd4));
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkVal({tag, ".out_valid"}, out_valid, v.expValid);
    checkVal({tag, ".out_pc"}, out_pc, v.expPc);
    checkVal({tag, ".out_inst"}, out_inst, v.expInst);
    checkVal({tag, ".out_pc_plus"}, out_pc_plus, v.expPlus);
    checkVal({tag, ".out_compr"}, out_compr, v.expCompr);
    checkVal({tag, ".out_misaligned"}, out_misaligned, v.expMis);
    checkVal({tag, ".count"}, count, v.expCount);
    checkVal({tag, ".in_ready"}, in_ready, v.expReady);
  endtask

  vec_t vecs[$];

  initial begin
    driveInputs(1, 0, 0, 0, 0, 0, 0);

    // rst iv pc inst mis fl ordy | valid pc inst plus compr mis count ready
    vecs = '{
      '{1,0,32'h0,32'h0,0,0,0,               0,32'h0,32'h00000013,32'h4,0,0,0,1},
      '{0,1,32'h100,32'h00A00093,0,0,0,      1,32'h100,32'h00A00093,32'h104,0,0,1,1},
      '{0,1,32'h200,32'h00004505,0,0,0,      1,32'h100,32'h00A00093,32'h104,0,0,2,0},
      '{0,1,32'h300,32'h11111113,0,0,0,      1,32'h100,32'h00A00093,32'h104,0,0,2,0},
      '{0,0,32'h0,32'h0,0,0,1,               1,32'h200,32'h00004505,32'h202,1,0,1,1},
      '{0,0,32'h0,32'h0,0,0,1,               0,32'h0,32'h00000013,32'h4,0,0,0,1},
      '{0,1,32'h400,32'h00000513,1,0,0,      1,32'h400,32'h00000513,32'h404,0,1,1,1},
      '{0,1,32'h500,32'h00008082,0,0,0,      1,32'h400,32'h00000513,32'h404,0,1,2,0},
      '{0,1,32'h600,32'h00000613,0,1,1,      0,32'h0,32'h00000013,32'h4,0,0,0,1},
      '{0,1,32'hFFFFFFFE,32'h00000001,0,0,0, 1,32'hFFFFFFFE,32'h00000001,32'h0,1,0,1,1},
      '{0,1,32'h700,32'h00000093,0,0,1,      1,32'h700,32'h00000093,32'h704,0,0,1,1},
      '{1,1,32'h800,32'h00000813,0,0,0,      0,32'h0,32'h00000013,32'h4,0,0,0,1},
      '{0,0,32'hDEAD,32'hBEEF,1,0,0,         0,32'h0,32'h00000013,32'h4,0,0,0,1}
    };

    for (int i = 0; i < vecs.size(); i++) begin
      driveInputs(vecs[i].rst, vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].mis, vecs[i].fl, vecs[i].ordy);
      applyStimulus();
      driveInputs(0, 0, 0, 0, 0, 0, 0);
      #1;
      checkVector(i, vecs[i]);
    end

    // Flush cycle: head still visible but out_valid held low
    driveInputs(1, 0, 0, 0, 0, 0, 0);
    applyStimulus();
    driveInputs(0, 1, 32'h900, 32'h00000913, 0, 0, 0);
    applyStimulus();
    driveInputs(0, 0, 0, 0, 0, 1, 1);
    #1;
    checkVal("flush.out_valid", out_valid, 0);
    checkVal("flush.out_pc", out_pc, 32'h900);
    checkVal("flush.count", count, 1);
    applyStimulus();
    driveInputs(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkVal("postflush.count", count, 0);
    checkVal("postflush.out_valid", out_valid, 0);

    // Full queue with simultaneous push and pop: only the pop happens
    driveInputs(0, 1, 32'hA00, 32'h00000A13, 0, 0, 0);
    applyStimulus();
    driveInputs(0, 1, 32'hB00, 32'h00000B13, 0, 0, 0);
    applyStimulus();
    driveInputs(0, 1, 32'hC00, 32'h00000C13, 0, 0, 1);
    #1;
    checkVal("fullpp.in_ready", in_ready, 0);
    applyStimulus();
    driveInputs(0, 0, 0, 0, 0, 0, 1);
    #1;
    checkVal("fullpp.count", count, 1);
    checkVal("fullpp.out_pc", out_pc, 32'hB00);
    applyStimulus();
    driveInputs(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkVal("fullpp.drained", count, 0);

`ifdef FETCH_QUEUE_STATS_EN
    // Two fills, five stalled cycles while full, then one flush
    driveInputs(1, 0, 0, 0, 0, 0, 0);
    applyStimulus();
    for (int i = 0; i < 7; i++) begin
      driveInputs(0, 1, 32'h1000 + 4 * i, 32'h00000013, 0, 0, 0);
      applyStimulus();
    end
    driveInputs(0, 0, 0, 0, 0, 1, 0);
    applyStimulus();
    driveInputs(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkVal("stats.stall_cycles", stall_cycles, 5);
    checkVal("stats.flush_events", flush_events, 1);
    driveInputs(1, 0, 0, 0, 0, 0, 0);
    applyStimulus();
    driveInputs(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkVal("stats.rst_stall", stall_cycles, 0);
    checkVal("stats.rst_flush", flush_events, 0);
`endif

    // Random traffic against the reference model
    driveInputs(1, 0, 0, 0, 0, 0, 0);
    applyStimulus();
    for (int i = 0; i < 400; i++) begin
      bit [31:0] inst;
      inst = $urandom;
      if ($urandom_range(1, 0) == 1) inst[1:0] = 2'b11;
      driveInputs($urandom_range(49, 0) == 0, $urandom_range(1, 0) == 1, $urandom, inst,
                  $urandom_range(3, 0) == 0, $urandom_range(9, 0) == 0, $urandom_range(1, 0) == 1);
      #1;
      checkOutput();
      applyStimulus();
    end
    driveInputs(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput();
`ifdef FETCH_QUEUE_STATS_EN
    checkVal("rand.stall_cycles", stall_cycles, mdlStall);
    checkVal("rand.flush_events", flush_events, mdlFlushEv);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
